led_pwm_fade: RTL
=================

// Module: led_pwm_fade
// PURPOSE
//  Downstream consumer of the debug LED pattern generator: takes its raw 16-bit on/off pattern and drives
//  the board LED pins with PWM brightness and a per-LED fading afterglow ("comet tail").
//  A lit input bit loads the LED level to `brightness`; once released, the level decays linearly to 0.
//  Sits between the pattern generator and the top-level LED pins, in the same clock domain.
// PARAMETERS
//  NUM_LED     16          number of LED channels
//  PWM_BITS    8           PWM counter / level / brightness width; PWM period = 2**PWM_BITS clk
//  DECAY_DIV   390625      clk cycles per decay tick (100 MHz -> 256 Hz); legal range >= 1
//  DECAY_STEP  8           level decrement per decay tick; 0 = no fade (legal)
// PORTS
//  clk         in   1         system clock
//  rst_n       in   1         asynchronous active-low reset
//  en          in   1         1 = drive LEDs, 0 = force all LEDs off and clear levels
//  brightness  in   PWM_BITS  peak duty loaded while an input bit is high
//  led_in      in   NUM_LED   raw pattern from the upstream generator; bit i high = LED i lit
//  led_out     out  NUM_LED   PWM-modulated LED drive, registered
//  pwm_sync    out  1         1-cycle pulse marking the first slot of each PWM period, aligned with led_out
// BEHAVIOUR
//  Reset (async assert, sync release): led_out=0, pwm_sync=0, pwm_cnt=0, prescaler=0, all level/duty=0, led_q=0.
//  led_q <= led_in: one register stage; no other synchronisation (same clock domain).
//  pwm_cnt: free-running PWM_BITS counter, wraps 2**PWM_BITS-1 -> 0.
//  Prescaler: counts 0..DECAY_DIV-1 and wraps; decay_tick=1 for one cycle when count==DECAY_DIV-1.
//   Free-running; not aligned to pwm_cnt.
//  level[i] update, in priority order:
//   en==0                -> level <= 0
//   led_q[i]==1          -> level <= brightness  (tracks brightness changes every cycle; wins over decay_tick)
//   decay_tick           -> level <= (level > DECAY_STEP) ? level-DECAY_STEP : 0  (saturating, never wraps)
//   else                 -> hold
//  duty[i] (shadow): duty <= level only in the cycle where pwm_cnt==2**PWM_BITS-1, so duty is constant for
//   a whole period and mid-period level changes cannot glitch the output.
//  led_out[i] <= en & (duty[i] > pwm_cnt); pwm_sync <= (pwm_cnt==0). Both are registered, so they lag
//   pwm_cnt by one cycle.
//   duty 0 -> never high; duty D -> high for exactly D consecutive cycles starting with the pwm_sync cycle.
//   Maximum on-time is (2**PWM_BITS-1)/2**PWM_BITS.
//  Latency from led_in rise to led_out: 2 clk to level, then to the next period boundary, then +1 clk.
//   Worst case is 2**PWM_BITS+3 clk.
//  en 1->0: led_out all 0 on the next clk edge regardless of duty; counters keep running.
//  en 0->1: levels are 0, so LEDs stay dark until led_q bits reassert; the first duty load happens at the
//   next period boundary.
//  rst_n asserted mid-period: all outputs drop to 0 immediately (async). After release, pwm_cnt restarts
//   at 0 and the first pwm_sync occurs 1 clk later.
// STRUCTURE
//  Package led_pkg: localparam PWM_BITS_DEF=8; typedef logic [PWM_BITS-1:0] led_level_t; the saturating
//   decrement function sat_dec(level, step).
//  Top holds led_q, pwm_cnt, prescaler and pwm_sync. One sub-module led_pwm_channel (level, duty, compare,
//   output flop) is instantiated NUM_LED times via generate. Shared pwm_cnt / decay_tick / period_end are
//   broadcast to all channels.
// TESTING (bench params: PWM_BITS=4, DECAY_DIV=4, DECAY_STEP=2)
//  1 Reset: run with en=1 and led_in=16'hFFFF, then pulse rst_n low mid-period.
//    -> led_out==0 and pwm_sync==0 within the same cycle; first pwm_sync 1 clk after release.
//  2 Steady: brightness=8, led_in=16'h0001 held.
//    -> from the 2nd period on, led_out[0] is high for exactly 8 of 16 cycles, starting on the pwm_sync
//       cycle; all other bits are 0.
//  3 Decay: brightness=15, hold led_in[3] for 2 periods, then release.
//    -> per-period high count of led_out[3] is non-increasing, reaches 0 within 32+17 clk, never
//       re-rises (no underflow).
//  4 Extremes: brightness=0 held -> led_out stays 0; brightness=15 -> 15 high / 1 low per period.
//    DECAY_STEP=0 build -> level holds forever after release.
//  5 Glitch-free: change brightness 15->3 at pwm_cnt=5 with led_in held.
//    -> the current period still shows 15 high cycles; the next period shows 3.
//  6 Enable: drop en mid-period -> led_out all 0 at the next edge. Restore en with led_in=0 -> stays 0.
//    Reassert led_in[7] -> lit from the following period.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and helpers for the PWM LED fader.
package led_pkg;

  localparam int PWM_BITS_DEF = 8;

  typedef logic [PWM_BITS_DEF-1:0] led_level_t;

  // Saturating decrement, computed at 32 bits so a step wider than the level cannot wrap.
  function automatic logic [31:0] sat_dec(input logic [31:0] level, input logic [31:0] step);
    logic [31:0] res;
    if (level > step) begin
      res = level - step;
    end else begin
      res = 32'd0;
    end
    return res;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: afterglow level, period-aligned duty shadow and PWM compare flop.
module led_pwm_channel
  import led_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int DECAY_STEP = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic                led_bit,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                decay_tick,
  input  logic                period_end,
  output logic                led
);

  logic [PWM_BITS-1:0] level;
  logic [PWM_BITS-1:0] level_next;
  logic [PWM_BITS-1:0] duty;

  // Next afterglow level: disable clears, a lit input reloads, a decay tick steps down.
  always_comb begin
    level_next = level;
    if (!en) begin
      level_next = {PWM_BITS{1'b0}};
    end else if (led_bit) begin
      level_next = brightness;
    end else if (decay_tick) begin
      level_next = PWM_BITS'(sat_dec(32'(level), 32'(DECAY_STEP)));
    end else begin
      level_next = level;
    end
  end

  // Level, duty shadow (only refreshed on the last slot so a period never glitches) and output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= {PWM_BITS{1'b0}};
      duty  <= {PWM_BITS{1'b0}};
      led   <= 1'b0;
    end else begin
      level <= level_next;
      if (period_end) begin
        duty <= level;
      end else begin
        duty <= duty;
      end
      led <= en & (duty > pwm_cnt);
    end
  end

endmodule

// File: rtl/led_pwm_fade.sv
// PWM brightness and linear-fade afterglow for the debug LED pattern.
module led_pwm_fade
  import led_pkg::*;
#(
  parameter int NUM_LED    = 16,
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int DECAY_DIV  = 390625,
  parameter int DECAY_STEP = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PWM_BITS-1:0] brightness,
  input  logic [NUM_LED-1:0]  led_in,
  output logic [NUM_LED-1:0]  led_out,
  output logic                pwm_sync
);

  localparam int                  PRE_W    = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(DECAY_DIV - 1);
  localparam logic [PWM_BITS-1:0] CNT_LAST = {PWM_BITS{1'b1}};

  logic [NUM_LED-1:0]  led_q;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PRE_W-1:0]    prescaler;
  logic                decay_tick;
  logic                period_end;

  assign decay_tick = (prescaler == PRE_LAST);
  assign period_end = (pwm_cnt == CNT_LAST);

  // Input stage, free-running PWM counter, decay prescaler and period-start marker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= {NUM_LED{1'b0}};
      pwm_cnt   <= {PWM_BITS{1'b0}};
      prescaler <= {PRE_W{1'b0}};
      pwm_sync  <= 1'b0;
    end else begin
      led_q   <= led_in;
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (decay_tick) begin
        prescaler <= {PRE_W{1'b0}};
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end
      pwm_sync <= (pwm_cnt == {PWM_BITS{1'b0}});
    end
  end

  for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
    led_pwm_channel #(
      .PWM_BITS  (PWM_BITS),
      .DECAY_STEP(DECAY_STEP)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .brightness(brightness),
      .led_bit   (led_q[i]),
      .pwm_cnt   (pwm_cnt),
      .decay_tick(decay_tick),
      .period_end(period_end),
      .led       (led_out[i])
    );
  end

endmodule
